// File: rtl/row_pad_sequencer.sv
// Row sequencer: top pad beats, strided body rows, bottom pad beats.
// Optional frame counter output enabled by ROW_SEQ_FRAME_CNT_EN.
module row_pad_sequencer #(
  parameter int ROWS    = 640,
  parameter int PAD_TOP = 1,
  parameter int PAD_BOT = 1,
  parameter int CW      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stride2,
  input  logic          abort,
  input  logic          row_ready,
  output logic          row_valid,
  output logic [CW-1:0] row_idx,
  output logic          pad_top,
  output logic          pad_bot,
  output logic          last_beat,
  output logic          busy,
  output logic          frame_done
`ifdef ROW_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    BODY,
    BOT,
    DONE
  } state_t;

  localparam bit HAS_TOP = (PAD_TOP > 0);
  localparam bit HAS_BOT = (PAD_BOT > 0);
  localparam logic [2:0] TOP_END =
    3'(HAS_TOP ? PAD_TOP - 1 : 0);
  localparam logic [2:0] BOT_END =
    3'(HAS_BOT ? PAD_BOT - 1 : 0);
  localparam logic [CW:0] ROWS_W = (CW+1)'(ROWS);

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [2:0]    pad_q, pad_d;
  logic          s2_q, s2_d;

  logic [CW:0]   step;
  logic [CW:0]   nxt;
  logic          body_end;
  logic          top_end;
  logic          bot_end;
  logic          xfer;

  // Beat decode: next index is one bit wider so it never wraps.
  always_comb begin
    step     = {{(CW-1){1'b0}}, s2_q, ~s2_q};
    nxt      = {1'b0, idx_q} + step;
    body_end = (nxt >= ROWS_W);
    top_end  = (pad_q == TOP_END);
    bot_end  = (pad_q == BOT_END);
    row_valid = (state_q == TOP) ||
                (state_q == BODY) ||
                (state_q == BOT);
    pad_top    = (state_q == TOP);
    pad_bot    = (state_q == BOT);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    row_idx    = idx_q;
    last_beat  = ((state_q == BOT) && bot_end) ||
                 ((state_q == BODY) && body_end &&
                  !HAS_BOT);
    xfer = row_valid && row_ready;
  end

  // Next state; abort wins over start and transfers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pad_d   = pad_q;
    s2_d    = s2_q;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      pad_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = HAS_TOP ? TOP : BODY;
            idx_d   = '0;
            pad_d   = '0;
            s2_d    = stride2;
          end
        end
        TOP: begin
          if (xfer) begin
            if (top_end) begin
              state_d = BODY;
              pad_d   = '0;
            end else begin
              pad_d = pad_q + 3'd1;
            end
          end
        end
        BODY: begin
          if (xfer) begin
            if (body_end) begin
              state_d = HAS_BOT ? BOT : DONE;
            end else begin
              idx_d = nxt[CW-1:0];
            end
          end
        end
        BOT: begin
          if (xfer) begin
            if (bot_end) begin
              state_d = DONE;
            end else begin
              pad_d = pad_q + 3'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
          pad_d   = '0;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          pad_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pad_q   <= '0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pad_q   <= pad_d;
      s2_q    <= s2_d;
    end
  end

`ifdef ROW_SEQ_FRAME_CNT_EN
  // Completed-frame counter; aborted frames never reach DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (state_q == DONE) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_row_pad_sequencer.sv
// Directed bench for row_pad_sequencer.
// Frame counter checks compile in with ROW_SEQ_FRAME_CNT_EN.
module tb_row_pad_sequencer;
  localparam int ROWS = 640;
  localparam int PT   = 1;
  localparam int PB   = 1;
  localparam int CW   = 15;

  logic clk = 1'b0;
  logic reset, start, stride2, abort, row_ready;
  logic row_valid, pad_top, pad_bot, last_beat;
  logic busy, frame_done;
  logic [CW-1:0] row_idx;

  logic s_start, s_s2, s_abort, s_ready;
  logic s_valid, s_pt, s_pb, s_last, s_busy, s_done;
  logic [2:0] s_idx;

`ifdef ROW_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt, s_cnt;
  int exp_frames = 0;
`endif

  int passed = 0;
  int checks = 0;

  always #5 clk = ~clk;

  row_pad_sequencer #(
    .ROWS(ROWS), .PAD_TOP(PT),
    .PAD_BOT(PB), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .start(start), .stride2(stride2),
    .abort(abort), .row_ready(row_ready),
    .row_valid(row_valid), .row_idx(row_idx),
    .pad_top(pad_top), .pad_bot(pad_bot),
    .last_beat(last_beat), .busy(busy),
    .frame_done(frame_done)
`ifdef ROW_SEQ_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  row_pad_sequencer #(
    .ROWS(5), .PAD_TOP(2),
    .PAD_BOT(0), .CW(3)
  ) dut5 (
    .clk(clk), .reset(reset),
    .start(s_start), .stride2(s_s2),
    .abort(s_abort), .row_ready(s_ready),
    .row_valid(s_valid), .row_idx(s_idx),
    .pad_top(s_pt), .pad_bot(s_pb),
    .last_beat(s_last), .busy(s_busy),
    .frame_done(s_done)
`ifdef ROW_SEQ_FRAME_CNT_EN
    , .frame_cnt(s_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic run_frame(input bit s2,
                           input int stall_k,
                           input int abort_k,
                           input int reset_k,
                           input bit hold_start,
                           input string tag);
    int s, nb, tot, k, stalls;
    logic [18:0] ev;
    s   = s2 ? 2 : 1;
    nb  = (ROWS + s - 1) / s;
    tot = PT + nb + PB;
    stride2 = s2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    stride2 = ~s2;
    k = 0;
    stalls = 0;
    while (k < tot) begin
      if (k < PT)
        ev = {4'b1100, 15'd0};
      else if (k < PT + nb)
        ev = {3'b100, (k == tot - 1),
              15'((k - PT) * s)};
      else
        ev = {3'b101, (k == tot - 1),
              15'((nb - 1) * s)};
      chk(tag, {row_valid, pad_top, pad_bot,
                last_beat, row_idx}, ev);
      if (k == abort_k) begin
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle", {row_valid, busy,
            frame_done, row_idx}, 0);
        tick();
        chk("abort_nodone", {row_valid, busy,
            frame_done}, 0);
        return;
      end
      if (k == reset_k) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset", {row_valid, pad_top,
            pad_bot, last_beat, busy,
            frame_done, row_idx}, 0);
`ifdef ROW_SEQ_FRAME_CNT_EN
        exp_frames = 0;
        chk("cnt_reset", frame_cnt, 0);
`endif
        return;
      end
      if (k == stall_k && stalls < 3) begin
        row_ready = 1'b0;
        stalls++;
      end else begin
        row_ready = 1'b1;
        k++;
      end
      if (k == tot && hold_start)
        start = 1'b1;
      tick();
    end
    row_ready = 1'b1;
    chk("done_pulse", {row_valid, busy,
        frame_done}, 3'b011);
`ifdef ROW_SEQ_FRAME_CNT_EN
    exp_frames++;
`endif
    tick();
    chk("done_one_cycle", {row_valid, busy,
        frame_done}, 0);
`ifdef ROW_SEQ_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, exp_frames);
`endif
    start = 1'b0;
    tick();
    chk("stay_idle", {row_valid, busy}, 0);
  endtask

  initial begin
    logic [6:0] exp5 [5];
    reset     = 1'b1;
    start     = 1'b0;
    stride2   = 1'b0;
    abort     = 1'b0;
    row_ready = 1'b1;
    s_start   = 1'b0;
    s_s2      = 1'b1;
    s_abort   = 1'b0;
    s_ready   = 1'b1;
    tick();
    tick();
    chk("reset_state", {row_valid, pad_top,
        pad_bot, last_beat, busy, frame_done,
        row_idx}, 0);
    chk("reset_state5", {s_valid, s_pt, s_pb,
        s_last, s_busy, s_done, s_idx}, 0);
    reset = 1'b0;
    tick();
    chk("post_reset", {row_valid, busy,
        frame_done, row_idx}, 0);

    run_frame(1'b0, -1, -1, -1, 1'b0, "s1");
    run_frame(1'b1, -1, -1, -1, 1'b0, "s2");
    run_frame(1'b0, PT + 5, -1, -1, 1'b0, "bp");
    run_frame(1'b0, -1, PT + 100, -1, 1'b0,
              "abort");
    run_frame(1'b0, -1, -1, -1, 1'b0,
              "after_abort");
    run_frame(1'b0, -1, -1, PT + 300, 1'b0,
              "reset");
    run_frame(1'b0, -1, -1, -1, 1'b1, "hold");
    run_frame(1'b1, -1, -1, -1, 1'b0, "again");

    exp5 = '{7'b1100000, 7'b1100000,
             7'b1000000, 7'b1000010,
             7'b1001100};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_s2    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rows5", {s_valid, s_pt, s_pb,
          s_last, s_idx}, exp5[i]);
      tick();
    end
    chk("rows5_done", {s_valid, s_busy,
        s_done}, 3'b011);
    tick();
    chk("rows5_idle", {s_valid, s_busy,
        s_done}, 0);
`ifdef ROW_SEQ_FRAME_CNT_EN
    chk("rows5_cnt", s_cnt, 1);
`endif

    $display("%0d/%0d checks passed",
             passed, checks);
    $finish;
  end
endmodule
